// File: rtl/mac_buf_pkg.sv
// Shared definitions for the MAC operand stream buffer.
//   DATA_W_DFLT / DEPTH_DFLT : default entry width and entries per bank
//   stream_state_e           : read-side state (IDLE = read bank empty, STREAM = streaming)
//   entry_msb()              : MSB bit position of entry k inside the parallel load vector
package mac_buf_pkg;

    localparam int unsigned DATA_W_DFLT = 8;
    localparam int unsigned DEPTH_DFLT  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

    // Entry 0 occupies the most significant slice of the load vector.
    function automatic int unsigned entry_msb(input int unsigned k,
                                              input int unsigned data_w,
                                              input int unsigned depth);
        return (depth - k) * data_w - 1;
    endfunction

endpackage

// File: rtl/mac_stream_buf_if.sv
// Bus bundle between the operand fetch side / MAC datapath and mac_stream_buf.
//   we, pin, load_ready  : parallel vector load with acceptance flag
//   i, res               : combinational random-read port
//   out_valid/out_ready, out_data, out_last : entry stream to the MAC array
//   ovf                  : sticky rejected-load flag
// slave = the buffer, master = the surrounding logic.
interface mac_stream_buf_if
    import mac_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned DEPTH  = DEPTH_DFLT
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic                    we;
    logic [DEPTH*DATA_W-1:0] pin;
    logic                    load_ready;
    logic [IDX_W-1:0]        i;
    logic [DATA_W-1:0]       res;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    ovf;

    modport master (
        output we, pin, i, out_ready,
        input  load_ready, res, out_valid, out_data, out_last, ovf
    );

    modport slave (
        input  we, pin, i, out_ready,
        output load_ready, res, out_valid, out_data, out_last, ovf
    );

endinterface

// File: rtl/mac_buf_bank.sv
// One DEPTH x DATA_W operand bank: whole-vector parallel load, synchronous clear,
// and two combinational read ports.
//   clk, clr  : clock, synchronous clear of all entries (active-high)
//   load, pin : capture the full parallel vector (entry 0 = MSB slice)
//   rptr/rdata: stream-pointer read port
//   ridx/rres : random-index read port
module mac_buf_bank
    import mac_buf_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DFLT,
    parameter  int unsigned DEPTH  = DEPTH_DFLT,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    load,
    input  logic [DEPTH*DATA_W-1:0] pin,
    input  logic [IDX_W-1:0]        rptr,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_W-1:0]       rdata,
    output logic [DATA_W-1:0]       rres
);

    logic [DATA_W-1:0] pin_ent [DEPTH];
    logic [DATA_W-1:0] mem_q   [DEPTH];

    // Split the flat load vector into index-ordered entries.
    for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
        assign pin_ent[k] = pin[entry_msb(k, DATA_W, DEPTH) -: DATA_W];
    end

    // Storage: clear wins over load.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem_q <= '{default: '0};
        end else if (load) begin
            mem_q <= pin_ent;
        end
    end

    assign rdata = mem_q[rptr];
    assign rres  = mem_q[ridx];

endmodule

// File: rtl/mac_stream_buf.sv
// MAC operand stream buffer: captures a DEPTH x DATA_W vector in one cycle, streams it
// in index order over valid/ready, and offers a combinational random read of the read bank.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mac_stream_buf_if.slave (load, random read, stream, ovf)
// Build option MAC_STREAM_BUF_PINGPONG_EN: two banks so the next vector can load while
// the current one streams; otherwise a single bank.
module mac_stream_buf
    import mac_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned DEPTH  = DEPTH_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    mac_stream_buf_if.slave  bus
);

    localparam int unsigned      IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
`ifdef MAC_STREAM_BUF_PINGPONG_EN
    localparam int unsigned      NBANK    = 2;
`else
    localparam int unsigned      NBANK    = 1;
`endif

    stream_state_e     state_q, state_d;
    logic [1:0]        full_q, full_d;      // bit 1 stays 0 in the single-bank build
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              ready_q, ready_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              load_c;
    logic              xfer_c;
    logic [DATA_W-1:0] bank_data [NBANK];
    logic [DATA_W-1:0] bank_res  [NBANK];

    assign xfer_c = (state_q == STREAM) && bus.out_ready;

    // Next-state: load commit, stream advance, bank toggles and registered status.
    always_comb begin
        state_d  = state_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        load_c   = 1'b0;

        if (bus.we) begin
            if (ready_q) begin
                load_c           = 1'b1;
                full_d[wr_sel_q] = 1'b1;
`ifdef MAC_STREAM_BUF_PINGPONG_EN
                wr_sel_d         = ~wr_sel_q;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (xfer_c) begin
            if (rd_ptr_q == LAST_IDX) begin
                full_d[rd_sel_q] = 1'b0;
                rd_ptr_d         = '0;
`ifdef MAC_STREAM_BUF_PINGPONG_EN
                rd_sel_d         = ~rd_sel_q;
`endif
            end else begin
                rd_ptr_d = rd_ptr_q + IDX_W'(1);
            end
        end

        // A bank that fills as the other drains keeps STREAM without a bubble.
        case (state_q)
            IDLE:    if (full_d[rd_sel_d])  state_d = STREAM;
            STREAM:  if (!full_d[rd_sel_d]) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = ~full_d[wr_sel_d];
        last_d  = full_d[rd_sel_d] && (rd_ptr_d == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b1;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        mac_buf_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk   (clk),
            .clr   (rst),
            .load  (load_c && (wr_sel_q == 1'(b))),
            .pin   (bus.pin),
            .rptr  (rd_ptr_q),
            .ridx  (bus.i),
            .rdata (bank_data[b]),
            .rres  (bank_res[b])
        );
    end

`ifdef MAC_STREAM_BUF_PINGPONG_EN
    assign bus.out_data = bank_data[rd_sel_q];
    assign bus.res      = bank_res[rd_sel_q];
`else
    assign bus.out_data = bank_data[0];
    assign bus.res      = bank_res[0];
`endif

    assign bus.out_valid  = (state_q == STREAM);
    assign bus.out_last   = last_q;
    assign bus.load_ready = ready_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_mac_stream_buf.sv
// Self-checking bench for mac_stream_buf (single-bank or MAC_STREAM_BUF_PINGPONG_EN build).
// Reference model: list of accepted vectors held per bank, counted loads/drains and a
// stream position; bank of the n-th vector is n modulo the bank count.
module tb_mac_stream_buf;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
`ifdef MAC_STREAM_BUF_PINGPONG_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif
    localparam logic [3:0]   LAST = 4'(DEPTH - 1);
    localparam logic [127:0] VEC  = 128'h00112233445566778899AABBCCDDEEFF;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0]  m_mem [2][16];
    int unsigned m_loads;
    int unsigned m_done;
    logic [3:0]  m_pos;
    logic        m_ovf;

    always #5 clk = ~clk;

    mac_stream_buf_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    mac_stream_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 16; k++)
                m_mem[b][k] = 8'h00;
        m_loads = 0;
        m_done  = 0;
        m_pos   = 4'd0;
        m_ovf   = 1'b0;
    endtask

    // Drive one cycle's inputs, check outputs against the model, then advance the model.
    task automatic step(input logic s_rst, input logic s_we, input logic [127:0] s_pin,
                        input logic [3:0] s_i, input logic s_rdy);
        int unsigned  cnt;
        logic         rb;
        logic         wb;
        logic [127:0] tmp;
        @(negedge clk);
        rst           = s_rst;
        bus.we        = s_we;
        bus.pin       = s_pin;
        bus.i         = s_i;
        bus.out_ready = s_rdy;
        #1;
        cnt = m_loads - m_done;
        rb  = (NB == 2) ? m_done[0] : 1'b0;
        check("out_valid",  32'(bus.out_valid),  32'(cnt != 0));
        check("load_ready", 32'(bus.load_ready), 32'(cnt < NB));
        check("ovf",        32'(bus.ovf),        32'(m_ovf));
        check("out_data",   32'(bus.out_data),   32'(m_mem[rb][m_pos]));
        check("out_last",   32'(bus.out_last),   32'((cnt != 0) && (m_pos == LAST)));
        check("res",        32'(bus.res),        32'(m_mem[rb][s_i]));
        if (s_rst) begin
            model_reset();
        end else begin
            if (s_we) begin
                if (cnt < NB) begin
                    wb  = (NB == 2) ? m_loads[0] : 1'b0;
                    tmp = s_pin;
                    for (int k = 0; k < 16; k++) begin
                        m_mem[wb][k[3:0]] = tmp[127:120];
                        tmp = tmp << 8;
                    end
                    m_loads++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if ((cnt != 0) && s_rdy) begin
                if (m_pos == LAST) begin
                    m_pos = 4'd0;
                    m_done++;
                end else begin
                    m_pos = m_pos + 4'd1;
                end
            end
        end
    endtask

    initial begin
        logic [127:0] va, vb, vc;
        int           ndrain;

        rst           = 1'b1;
        bus.we        = 1'b0;
        bus.pin       = '0;
        bus.i         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset then idle: every index reads zero.
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, '0, 4'(k), 1'b1);
            check("idle_res", 32'(bus.res), 32'h0);
        end
        check("idle_valid", 32'(bus.out_valid), 32'h0);
        check("idle_ready", 32'(bus.load_ready), 32'h1);
        check("idle_ovf", 32'(bus.ovf), 32'h0);

        // Known vector streamed at full rate.
        step(1'b0, 1'b1, VEC, 4'd3, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, '0, 4'd3, 1'b1);
            check("stream_data", 32'(bus.out_data), 32'(k * 17));
            check("stream_last", 32'(bus.out_last), 32'(k == 15));
            check("stream_res", 32'(bus.res), 32'h33);
        end
        step(1'b0, 1'b0, '0, 4'd3, 1'b1);
        check("drained_valid", 32'(bus.out_valid), 32'h0);

        // Backpressure for three cycles at entry 5.
        step(1'b0, 1'b1, VEC, 4'd0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) begin
                for (int h = 0; h < 3; h++) begin
                    step(1'b0, 1'b0, '0, 4'd0, 1'b0);
                    check("bp_hold_data", 32'(bus.out_data), 32'h55);
                    check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
                end
            end
            step(1'b0, 1'b0, '0, 4'd0, 1'b1);
            check("bp_seq", 32'(bus.out_data), 32'(k * 17));
        end
        step(1'b0, 1'b0, '0, 4'd0, 1'b1);

        // Loads during a stream: second accepted only with two banks, third always rejected.
        va = {$urandom(), $urandom(), $urandom(), $urandom()};
        vb = {$urandom(), $urandom(), $urandom(), $urandom()};
        vc = {$urandom(), $urandom(), $urandom(), $urandom()};
        step(1'b0, 1'b1, va, 4'd0, 1'b1);
        step(1'b0, 1'b0, '0, 4'd0, 1'b1);
        step(1'b0, 1'b1, vb, 4'd0, 1'b1);
        step(1'b0, 1'b1, vc, 4'd0, 1'b1);
        step(1'b0, 1'b0, '0, 4'd0, 1'b1);
        check("ovf_set", 32'(bus.ovf), 32'h1);
        check("busy_ready", 32'(bus.load_ready), 32'h0);
        ndrain = (NB == 2) ? 28 : 12;
        for (int k = 0; k < ndrain; k++) begin
            step(1'b0, 1'b0, '0, 4'(k), 1'b1);
            check("no_bubble_valid", 32'(bus.out_valid), 32'h1);
        end
        step(1'b0, 1'b0, '0, 4'd0, 1'b1);
        check("all_drained", 32'(bus.out_valid), 32'h0);
        check("ovf_sticky", 32'(bus.ovf), 32'h1);

        // Reset mid-stream at entry 7, then a fresh load restarts at entry 0.
        step(1'b1, 1'b0, '0, 4'd3, 1'b1);
        step(1'b0, 1'b1, VEC, 4'd3, 1'b1);
        for (int k = 0; k < 7; k++)
            step(1'b0, 1'b0, '0, 4'd3, 1'b1);
        step(1'b1, 1'b0, '0, 4'd3, 1'b1);
        check("pre_rst_data", 32'(bus.out_data), 32'h77);
        step(1'b0, 1'b0, '0, 4'd3, 1'b1);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_ready", 32'(bus.load_ready), 32'h1);
        check("rst_res", 32'(bus.res), 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'h0);
        step(1'b0, 1'b1, VEC, 4'd3, 1'b1);
        step(1'b0, 1'b0, '0, 4'd3, 1'b1);
        check("restart_valid", 32'(bus.out_valid), 32'h1);
        check("restart_data", 32'(bus.out_data), 32'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 7) == 0),
                 {$urandom(), $urandom(), $urandom(), $urandom()},
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_stream_buf.md
# mac_stream_buf

Parametrised successor to the fixed 16- and 64-entry MAC operand buffers. It captures a DEPTH×DATA_W operand vector from a wide parallel bus in one cycle. It then streams the entries to the MAC datapath in index order over a valid/ready handshake, and keeps a combinational random-read port for index-addressed access. It sits between the operand fetch bus and the MAC array; an optional second bank allows the next vector to load while the current one streams.

## Interface
- DATA_W, 8, width of one entry
- DEPTH, 16, entries per bank; power of two, ≥2 (16 and 64 in current use)
- IDX_W, $clog2(DEPTH), index width
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- we  in  1  load request; accepted only when load_ready=1
- pin  in  DEPTH*DATA_W  parallel operand vector; entry k = pin[(DEPTH-k)*DATA_W-1 -: DATA_W] (entry 0 = MSB slice)
- load_ready  out  1  a bank is free to accept a load
- i  in  IDX_W  random-read index
- res  out  DATA_W  combinational read of entry i of the read bank
- out_valid  out  1  out_data holds a valid entry
- out_ready  in  1  consumer accepts out_data
- out_data  out  DATA_W  entry at current stream pointer of read bank
- out_last  out  1  high with out_valid when pointer = DEPTH-1
- ovf  out  1  sticky: we asserted while load_ready=0

## Operation
- Per-bank full flag. Load commits when we && load_ready; pin is written to the write bank and the flag is set.
- FSM per read side: IDLE (read bank empty, out_valid=0) → STREAM (read bank full, out_valid=1).
- Transfer = out_valid && out_ready. Each transfer increments rd_ptr. A transfer at rd_ptr=DEPTH-1 clears the read bank's full flag and wraps rd_ptr to 0.
- out_data and res are combinational from storage. res addresses the read bank regardless of its full flag.
- out_valid stays high and out_data stays stable while out_ready=0 (no drop, no reorder).
- we with load_ready=0: ignored, no storage change, ovf set. ovf is cleared only by rst.
- Reset values: out_valid=0, out_last=0, load_ready=1, ovf=0, rd_ptr=0, all full flags=0, all storage=0 (so res=0, out_data=0).
- rst mid-stream aborts the vector. Remaining entries are discarded.

## Timing
- Load latency: load accepted at edge n → out_valid=1, out_data=entry 0 in cycle n+1.
- Throughput: one entry per cycle with out_ready held high; DEPTH cycles per vector.
- The load_ready update is registered. load_ready reflects flags after the previous edge.
- Single-bank simultaneous case: the last transfer and we arrive in the same cycle. load_ready is 0, so the load is rejected (ovf set). load_ready=1 the next cycle.
- res follows i in the same cycle; no pipeline stage.

## Configuration
- MAC_STREAM_BUF_PINGPONG_EN defined: two banks. Write pointer toggles after each accepted load; read bank toggles after each last transfer. load_ready = write bank empty.
  - A load into the idle bank during the last transfer of the other bank is accepted. The next cycle streams entry 0 of the new bank with out_valid continuously high, with no bubble.
  - Two loads during one stream fill both banks; load_ready=0 until the first bank drains.
- Not defined: one bank; load_ready = !full; no overlap of load and stream.

## Structure
- Package mac_buf_pkg: default DATA_W/DEPTH localparams, FSM state enum (IDLE, STREAM), and a slice function computing the entry k bit range of pin.
- Sub-module mac_buf_bank contains DEPTH×DATA_W storage, parallel load enable, synchronous clear, and two combinational read ports (stream pointer, random index). It is instantiated once, or twice under MAC_STREAM_BUF_PINGPONG_EN. Control FSM, pointers, and flags live in the top.

## Test plan
- Reset then idle: out_valid=0, load_ready=1, ovf=0, res=8'h00 for all i.
- Load pin=128'h00112233445566778899AABBCCDDEEFF with out_ready=1 → out_data 00,11,…,FF on 16 consecutive cycles starting one cycle after load, out_last only on FF, then out_valid=0; res with i=3 reads 8'h33.
- Backpressure: out_ready low for 3 cycles at entry 5 → out_data held at 8'h55, out_valid held high, no entry skipped.
- Single-bank: we during streaming → ignored, ovf=1 and stays set; stream still outputs the original vector.
- Ping-pong build: load A, then load B during A's stream → A's 16 entries immediately followed by B's entry 0 with no out_valid gap; a third load during A is rejected with ovf=1.
- rst asserted at entry 7 → next cycle out_valid=0, load_ready=1, res=8'h00; a fresh load streams from entry 0.
